// File: rtl/div_32_seq.sv
// div_32_seq: sequential 32-bit divider, one quotient bit per clock.
// Build option: define DIV_32_SIGNED_EN for two's-complement operands.
//
// Ports:
//   clk, rst_n    rising-edge clock, async active-low reset
//   start         request a division (sampled only in IDLE)
//   A, B          dividend / divisor, sampled on the accepting edge
//   HI, LO        remainder / quotient, registered, held until next result
//   busy          high while a division is in flight
//   done          one-cycle pulse when HI/LO are written
//   div_by_zero   set with done when B was 0, held until the next done

module div_32_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [4:0]  cnt_q;
    logic [32:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic        neg_q_q;
    logic        neg_r_q;
    logic        dbz_q;

    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        sgn_q;
    logic        sgn_r;

    logic [32:0] rem_sh;
    logic [33:0] trial;
    logic        fit;
    logic [31:0] lo_fix;
    logic [31:0] hi_fix;

`ifdef DIV_32_SIGNED_EN
    assign a_mag = A[31] ? (~A + 32'd1) : A;
    assign b_mag = B[31] ? (~B + 32'd1) : B;
    assign sgn_q = A[31] ^ B[31];
    assign sgn_r = A[31];
`else
    assign a_mag = A;
    assign b_mag = B;
    assign sgn_q = 1'b0;
    assign sgn_r = 1'b0;
`endif

    // Shift {rem, quo} left, then try to subtract the divisor.
    // The extra top bit of trial is the borrow: clear means it fits.
    assign rem_sh = {rem_q[31:0], quo_q[31]};
    assign trial  = {1'b0, rem_sh} - {2'b00, dvs_q};
    assign fit    = ~trial[33];

    assign lo_fix = neg_q_q ? (~quo_q + 32'd1) : quo_q;
    assign hi_fix = neg_r_q ? (~rem_q[31:0] + 32'd1) : rem_q[31:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (B == 32'd0) ? FIX : CALC;
                end
            end
            CALC: begin
                if (cnt_q == 5'd31) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= 5'd0;
            rem_q       <= 33'd0;
            quo_q       <= 32'd0;
            dvs_q       <= 32'd0;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            dbz_q       <= 1'b0;
            HI          <= 32'd0;
            LO          <= 32'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        cnt_q <= 5'd0;
                        if (B == 32'd0) begin
                            // Preload the zero-divisor result so FIX
                            // writes it through the normal path.
                            rem_q   <= {1'b0, A};
                            quo_q   <= 32'hFFFF_FFFF;
                            dvs_q   <= 32'd0;
                            neg_q_q <= 1'b0;
                            neg_r_q <= 1'b0;
                            dbz_q   <= 1'b1;
                        end else begin
                            rem_q   <= 33'd0;
                            quo_q   <= a_mag;
                            dvs_q   <= b_mag;
                            neg_q_q <= sgn_q;
                            neg_r_q <= sgn_r;
                            dbz_q   <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    cnt_q <= cnt_q + 5'd1;
                    rem_q <= fit ? trial[32:0] : rem_sh;
                    quo_q <= {quo_q[30:0], fit};
                end
                FIX: begin
                    HI          <= hi_fix;
                    LO          <= lo_fix;
                    div_by_zero <= dbz_q;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_32_seq.sv
// tb_div_32_seq: scoreboard bench for div_32_seq.
// Works in both builds (DIV_32_SIGNED_EN defined or not).

module tb_div_32_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    div_32_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .A           (A),
        .B           (B),
        .HI          (HI),
        .LO          (LO),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Reference result packed as {dbz, hi, lo}.
    function automatic logic [64:0] model(input logic [31:0] a,
                                          input logic [31:0] b);
        int sa;
        int sd;
        int q;
        int r;
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
`ifdef DIV_32_SIGNED_EN
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return {1'b0, 32'd0, 32'h8000_0000};
        sa = a;
        sd = b;
        q  = sa / sd;
        r  = sa % sd;
        return {1'b0, r, q};
`else
        sa = 0;
        sd = 0;
        q  = 0;
        r  = 0;
        return {1'b0, a % b, a / b};
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] hi, input logic [31:0] lo,
                         input logic dbz, input int lat);
        exp_t e;
        e.hi  = hi;
        e.lo  = lo;
        e.dbz = dbz;
        e.lat = lat;
        sb.push_back(e);
        A     = a;
        B     = b;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic drive_model(input logic [31:0] a, input logic [31:0] b);
        logic [64:0] m;
        m = model(a, b);
        drive(a, b, m[63:32], m[31:0], m[64], (b == 32'd0) ? 1 : 33);
    endtask

    task automatic wait_done(input string tag, input int base);
        int   lat;
        int   bad;
        exp_t e;
        lat = -1;
        bad = 0;
        for (int k = 1; k <= 40; k++) begin
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            step();
            if (done === 1'b1) begin
                lat = base + k;
                break;
            end
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL %s busy_window: bad cycles %0d want 0", tag, bad);
        end
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard: empty want 1 entry", tag);
            return;
        end
        e = sb.pop_front();
        checks++;
        if (lat !== e.lat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", tag, lat, e.lat);
        end
        checks++;
        if (LO !== e.lo) begin
            errors++;
            $display("FAIL %s LO: got %h want %h", tag, LO, e.lo);
        end
        checks++;
        if (HI !== e.hi) begin
            errors++;
            $display("FAIL %s HI: got %h want %h", tag, HI, e.hi);
        end
        checks++;
        if (div_by_zero !== e.dbz) begin
            errors++;
            $display("FAIL %s dbz: got %b want %b", tag, div_by_zero, e.dbz);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_at_done: got %b want 0", tag, busy);
        end
    endtask

    task automatic check_zero(input string tag);
        checks++;
        if ({HI, LO, busy, done, div_by_zero} !== 67'd0) begin
            errors++;
            $display("FAIL %s outputs: got HI=%h LO=%h b=%b d=%b z=%b want 0",
                     tag, HI, LO, busy, done, div_by_zero);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        A     = 32'd0;
        B     = 32'd0;
        #2;
        check_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        drive(32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33);
        wait_done("basic", 0);
    endtask

    task automatic test_negative();
`ifdef DIV_32_SIGNED_EN
        drive(32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0, 33);
`else
        drive(32'hFFFF_FF9C, 32'd7, 32'd2, 32'h2492_4916, 1'b0, 33);
`endif
        wait_done("negative", 0);
    endtask

    task automatic test_div_zero();
        drive(32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 1);
        wait_done("div_zero", 0);
    endtask

    task automatic test_overflow();
`ifdef DIV_32_SIGNED_EN
        drive(32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 33);
`else
        drive(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33);
`endif
        wait_done("overflow", 0);
    endtask

    task automatic test_reset_abort();
        int seen;
        drive(32'd1000, 32'd3, 32'd1, 32'd333, 1'b0, 33);
        repeat (9) step();
        rst_n = 1'b0;
        #1;
        check_zero("abort_reset");
        void'(sb.pop_back());
        step();
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (done === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d done pulses want 0", seen);
        end
        drive(32'd9, 32'd2, 32'd1, 32'd4, 1'b0, 33);
        wait_done("after_reset", 0);
    endtask

    task automatic test_ignore_start();
        drive(32'd1000, 32'd3, 32'd1, 32'd333, 1'b0, 33);
        repeat (4) step();
        A     = 32'd50;
        B     = 32'd5;
        start = 1'b1;
        step();
        start = 1'b0;
        A     = 32'd7;
        B     = 32'd1;
        wait_done("ignore_start", 5);
    endtask

    task automatic test_back_to_back();
        drive(32'd77, 32'd8, 32'd5, 32'd9, 1'b0, 33);
        wait_done("b2b_first", 0);
        drive(32'd1234567, 32'd1000, 32'd567, 32'd1234, 1'b0, 33);
        wait_done("b2b_second", 0);
        for (int i = 0; i < 6; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = (i == 3) ? 32'd0 : ((i % 2 == 0) ? $urandom : $urandom_range(1, 300));
            drive_model(a, b);
            wait_done("b2b_random", 0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_div_zero();
        test_overflow();
        test_reset_abort();
        test_ignore_start();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
